periferico_receptor: RTL and testbench
======================================

PERIFERICO_RECEPTOR -- requirements
Module: periferico_receptor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of 16-bit FIFO entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port send  input  2  request from processor: 2'b01 = request, 2'b00 = idle, 2'b1x = illegal.
REQ-005 SHALL have port dado  input  16  data word, valid while send==2'b01.
REQ-006 SHALL have port ack  output  2  acknowledge: 2'b01 = asserted, 2'b00 = deasserted; registered.
REQ-007 SHALL have port rd_en  input  1  consumer pop request.
REQ-008 SHALL have port rd_data  output  16  FIFO head word (first-word fall-through).
REQ-009 SHALL have port empty  output  1  FIFO holds zero words.
REQ-010 SHALL have port full  output  1  FIFO holds DEPTH words.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of stored words.
REQ-012 SHALL have port erro  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL implement a four-phase send/ack handshake with FSM states IDLE, ESPERA, ACK.
REQ-014 In IDLE with send==2'b01 and full==0, SHALL write dado into the FIFO at that edge and enter ACK; ack==2'b01 from the following cycle (latency 1).
REQ-015 In IDLE with send==2'b01 and full==1, SHALL enter ESPERA with ack held at 2'b00 and nothing written.
REQ-016 In ESPERA, SHALL write dado and enter ACK on the first edge where full==0; if send returns to 2'b00 first, SHALL return to IDLE without writing.
REQ-017 In ACK, SHALL hold ack==2'b01 until send==2'b00 is sampled, then enter IDLE with ack==2'b00 the next cycle.
REQ-018 SHALL write exactly one word per handshake, regardless of how long send stays 2'b01.
REQ-019 SHALL set erro on any edge sampling send[1]==1, SHALL treat that sample as idle, and SHALL clear erro only on reset.
REQ-020 SHALL pop the head word on an edge with rd_en==1 and empty==0; rd_en with empty==1 SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; a pop while full frees space usable by a push on the next edge, not the same edge.
REQ-022 rd_data SHALL equal the head entry when empty==0 and 16'h0000 when empty==1.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-024 rst==0 SHALL immediately force FSM=IDLE, ack=2'b00, count=0, empty=1, full=0, erro=0, pointers=0, rd_data=16'h0000.
REQ-025 Reset asserted mid-handshake SHALL discard the transaction and all FIFO contents; after release, the FSM SHALL start from IDLE and sample send on the first edge.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, ESPERA, ACK) and constants SEND_REQ=2'b01, SEND_IDLE=2'b00, ACK_ON=2'b01 and ACK_OFF=2'b00 in shared package periferico_pkg.
REQ-027 SHALL instantiate the storage as one sub-module fifo_dado (DEPTH x 16, push/pop/full/empty/count); the handshake FSM SHALL stay in the top module.

Verification
REQ-028 Single transfer: after reset, send=01, dado=16'hA5A5 -> ack=01 one cycle later; send=00 -> ack=00; rd_data=16'hA5A5, count=1.
REQ-029 Fill/full: 4 handshakes with 16'h0001..16'h0004 and no pops -> full=1; 5th send=01 -> ack stays 00 (ESPERA); one pop -> 5th word written, ack=01, pop order 1,2,3,4,5.
REQ-030 Long request: send=01 held for 10 cycles -> exactly one word written, count=1.
REQ-031 Simultaneous: count=2, handshake write coinciding with rd_en=1 -> count stays 2, head advances; rd_en with empty=1 -> no change, rd_data=16'h0000.
REQ-032 Error: send=2'b10 for one cycle -> erro=1 and stays set; no write, ack=00.
REQ-033 Reset mid-operation: rst=0 while in ACK with count=3 -> ack=00, count=0, empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/periferico_pkg.sv
// Shared types and constants for the periferico_receptor handshake receiver.
package periferico_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ESPERA = 2'b01,
        ACK    = 2'b10
    } estado_t;

    localparam logic [1:0] SEND_REQ  = 2'b01;
    localparam logic [1:0] SEND_IDLE = 2'b00;
    localparam logic [1:0] ACK_ON    = 2'b01;
    localparam logic [1:0] ACK_OFF   = 2'b00;

    // Any send code with the upper bit set is outside the protocol.
    function automatic logic send_ilegal(input logic [1:0] code);
        return code[1];
    endfunction

endpackage

// File: rtl/fifo_dado.sv
// First-word fall-through FIFO holding the words received by the handshake.
module fifo_dado #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [15:0]              din,
    input  logic                     pop,
    output logic [15:0]              dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1'b1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Status flags and guarded push/pop so an overflow or underflow is impossible.
    always_comb begin
        full_s    = (count_r == CNT_DEPTH);
        empty_s   = (count_r == {(AW + 1){1'b0}});
        push_ok_s = push & ~full_s;
        pop_ok_s  = pop & ~empty_s;
    end

    // Storage array; contents are meaningless while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head word is presented as zero when nothing is stored.
    always_comb begin
        if (empty_s) begin
            dout = 16'h0000;
        end else begin
            dout = mem_r[rd_ptr_r];
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/periferico_receptor.sv
// Four-phase send/ack receiver that stores each transferred word in a FIFO.
module periferico_receptor
    import periferico_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               send,
    input  logic [15:0]              dado,
    output logic [1:0]               ack,
    input  logic                     rd_en,
    output logic [15:0]              rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     erro
);

    estado_t    state_r;
    logic [1:0] ack_r;
    logic       erro_r;
    logic       send_req_s;
    logic       send_bad_s;
    logic       push_s;
    logic       pop_s;

    // A word is taken only while waiting for a request and the FIFO has room.
    always_comb begin
        send_req_s = (send == SEND_REQ);
        send_bad_s = send_ilegal(send);
        pop_s      = rd_en & ~empty;
        if (((state_r == IDLE) || (state_r == ESPERA)) && send_req_s && !full) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Handshake FSM; illegal send codes behave like SEND_IDLE apart from erro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            ack_r   <= ACK_OFF;
            erro_r  <= 1'b0;
        end else begin
            erro_r <= erro_r | send_bad_s;
            case (state_r)
                IDLE: begin
                    if (push_s) begin
                        state_r <= ACK;
                        ack_r   <= ACK_ON;
                    end else if (send_req_s) begin
                        state_r <= ESPERA;
                        ack_r   <= ACK_OFF;
                    end else begin
                        state_r <= IDLE;
                        ack_r   <= ACK_OFF;
                    end
                end
                ESPERA: begin
                    if (push_s) begin
                        state_r <= ACK;
                        ack_r   <= ACK_ON;
                    end else if (send_req_s) begin
                        state_r <= ESPERA;
                        ack_r   <= ACK_OFF;
                    end else begin
                        state_r <= IDLE;
                        ack_r   <= ACK_OFF;
                    end
                end
                ACK: begin
                    if (send_req_s) begin
                        state_r <= ACK;
                        ack_r   <= ACK_ON;
                    end else begin
                        state_r <= IDLE;
                        ack_r   <= ACK_OFF;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ack_r   <= ACK_OFF;
                end
            endcase
        end
    end

    fifo_dado #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (dado),
        .pop   (pop_s),
        .dout  (rd_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign ack  = ack_r;
    assign erro = erro_r;

endmodule

// File: tb/tb_periferico_receptor.sv
// Directed bench for periferico_receptor with a queue scoreboard of written words.
module tb_periferico_receptor;

    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst;
    logic [1:0]             send;
    logic [15:0]            dado;
    logic [1:0]             ack;
    logic                   rd_en;
    logic [15:0]            rd_data;
    logic                   empty;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   erro;

    int checks;
    int failures;
    logic [15:0] sb_q[$];

    periferico_receptor #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .send    (send),
        .dado    (dado),
        .ack     (ack),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .erro    (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full handshake: request, bounded wait for ack, release, check ack drops.
    task automatic handshake(input logic [15:0] w);
        logic got;
        got  = 1'b0;
        send = 2'b01;
        dado = w;
        sb_q.push_back(w);
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack === 2'b01) begin
                got = 1'b1;
                break;
            end
        end
        chk("hs_ack_on", {31'd0, got}, 32'd1);
        send = 2'b00;
        step();
        chk("hs_ack_off", {30'd0, ack}, 32'd0);
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] e;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 16'h0000;
        chk(tag, {16'd0, rd_data}, {16'd0, e});
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        send     = 2'b00;
        dado     = 16'h0000;
        rd_en    = 1'b0;
        #2;
        chk("rst_ack",   {30'd0, ack}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full",  {31'd0, full}, 32'd0);
        chk("rst_erro",  {31'd0, erro}, 32'd0);
        chk("rst_rd",    {16'd0, rd_data}, 32'd0);
        step();
        rst = 1'b1;
        step();

        // single transfer, ack exactly one cycle after the request edge
        send = 2'b01;
        dado = 16'hA5A5;
        sb_q.push_back(16'hA5A5);
        step();
        chk("single_ack_lat", {30'd0, ack}, 32'd1);
        chk("single_count", {29'd0, count}, 32'd1);
        send = 2'b00;
        step();
        chk("single_ack_off", {30'd0, ack}, 32'd0);
        chk("single_head", {16'd0, rd_data}, {16'd0, sb_q[0]});
        pop_check("single_pop");
        chk("single_empty", {31'd0, empty}, 32'd1);

        // fill to full, fifth request waits in ESPERA until a pop
        for (int k = 1; k <= 4; k++) handshake(16'(k));
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {29'd0, count}, 32'd4);
        send = 2'b01;
        dado = 16'h0005;
        sb_q.push_back(16'h0005);
        step();
        chk("espera_ack0", {30'd0, ack}, 32'd0);
        step();
        chk("espera_ack1", {30'd0, ack}, 32'd0);
        chk("espera_count", {29'd0, count}, 32'd4);
        pop_check("fill_pop1");
        chk("espera_no_same_edge", {30'd0, ack}, 32'd0);
        chk("espera_count3", {29'd0, count}, 32'd3);
        step();
        chk("espera_ack_on", {30'd0, ack}, 32'd1);
        chk("espera_count4", {29'd0, count}, 32'd4);
        send = 2'b00;
        step();
        chk("espera_ack_off", {30'd0, ack}, 32'd0);
        for (int k = 2; k <= 5; k++) pop_check("fill_order");
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_rd0", {16'd0, rd_data}, 32'd0);

        // long request writes one word only
        send = 2'b01;
        dado = 16'hBEEF;
        sb_q.push_back(16'hBEEF);
        repeat (10) step();
        chk("long_count", {29'd0, count}, 32'd1);
        chk("long_ack", {30'd0, ack}, 32'd1);
        send = 2'b00;
        step();
        chk("long_ack_off", {30'd0, ack}, 32'd0);

        // simultaneous push and pop at count 2
        handshake(16'h1111);
        chk("sim_count2", {29'd0, count}, 32'd2);
        send = 2'b01;
        dado = 16'h2222;
        sb_q.push_back(16'h2222);
        pop_check("sim_pop_head");
        chk("sim_count", {29'd0, count}, 32'd2);
        chk("sim_ack", {30'd0, ack}, 32'd1);
        chk("sim_head_adv", {16'd0, rd_data}, {16'd0, sb_q[0]});
        send = 2'b00;
        step();
        pop_check("sim_pop_a");
        pop_check("sim_pop_b");
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("underflow_count", {29'd0, count}, 32'd0);
        chk("underflow_empty", {31'd0, empty}, 32'd1);
        chk("underflow_rd0", {16'd0, rd_data}, 32'd0);

        // illegal send code sets sticky erro
        send = 2'b10;
        dado = 16'hDEAD;
        step();
        chk("err_set", {31'd0, erro}, 32'd1);
        chk("err_ack", {30'd0, ack}, 32'd0);
        chk("err_count", {29'd0, count}, 32'd0);
        send = 2'b00;
        repeat (3) step();
        chk("err_sticky", {31'd0, erro}, 32'd1);

        // asynchronous reset while in ACK with three words stored
        handshake(16'h0A0A);
        handshake(16'h0B0B);
        send = 2'b01;
        dado = 16'h0C0C;
        step();
        chk("mid_ack", {30'd0, ack}, 32'd1);
        chk("mid_count", {29'd0, count}, 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("arst_ack", {30'd0, ack}, 32'd0);
        chk("arst_count", {29'd0, count}, 32'd0);
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_erro", {31'd0, erro}, 32'd0);
        chk("arst_rd0", {16'd0, rd_data}, 32'd0);
        sb_q.delete();
        #2 rst = 1'b1;
        send = 2'b00;
        step();
        handshake(16'h7E57);
        chk("post_count", {29'd0, count}, 32'd1);
        pop_check("post_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
